// File: rtl/nasti_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// nasti_lite_reg_slave
//
// Purpose:
//   NASTI-Lite responder that ends a Lite master port on a bank of NUM_REGS
//   software-visible control registers. It accepts single-beat writes and
//   reads, applies byte strobes, echoes ID/USER, and answers OKAY or DECERR.
//   Register contents drive reg_q directly. Each register has a one-cycle
//   write pulse on reg_wr, asserted the cycle after that register is written.
//
// Optional feature (compile-time macro):
//   NASTI_LITE_REG_PROT_EN
//     When defined, a write with aw_prot[0]=0 (unprivileged) to an in-range
//     register is dropped and answered SLVERR, with no reg_wr pulse.
//     When undefined, aw_prot and ar_prot are ignored.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   lite_aw_*             write address channel (id/addr/prot/user/valid/ready)
//   lite_w_*              write data channel (data/strb/user/valid/ready)
//   lite_b_*              write response channel (id/resp/user/valid/ready)
//   lite_ar_*             read address channel (id/addr/prot/user/valid/ready)
//   lite_r_*              read data channel (id/data/resp/user/valid/ready)
//   reg_q                 register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                per-register write pulse
// ---------------------------------------------------------------------------
module nasti_lite_reg_slave #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int NUM_REGS   = 8
) (
   input  logic                           clk,
   input  logic                           rst,

   input  logic [ID_WIDTH-1:0]            lite_aw_id,
   input  logic [ADDR_WIDTH-1:0]          lite_aw_addr,
   input  logic [2:0]                     lite_aw_prot,
   input  logic [USER_WIDTH-1:0]          lite_aw_user,
   input  logic                           lite_aw_valid,
   output logic                           lite_aw_ready,

   input  logic [DATA_WIDTH-1:0]          lite_w_data,
   input  logic [DATA_WIDTH/8-1:0]        lite_w_strb,
   input  logic [USER_WIDTH-1:0]          lite_w_user,
   input  logic                           lite_w_valid,
   output logic                           lite_w_ready,

   output logic [ID_WIDTH-1:0]            lite_b_id,
   output logic [1:0]                     lite_b_resp,
   output logic [USER_WIDTH-1:0]          lite_b_user,
   output logic                           lite_b_valid,
   input  logic                           lite_b_ready,

   input  logic [ID_WIDTH-1:0]            lite_ar_id,
   input  logic [ADDR_WIDTH-1:0]          lite_ar_addr,
   input  logic [2:0]                     lite_ar_prot,
   input  logic [USER_WIDTH-1:0]          lite_ar_user,
   input  logic                           lite_ar_valid,
   output logic                           lite_ar_ready,

   output logic [ID_WIDTH-1:0]            lite_r_id,
   output logic [DATA_WIDTH-1:0]          lite_r_data,
   output logic [1:0]                     lite_r_resp,
   output logic [USER_WIDTH-1:0]          lite_r_user,
   output logic                           lite_r_valid,
   input  logic                           lite_r_ready,

   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_WIDTH - OFF_W;
   localparam int RIDX_W = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_RESP}         rstate_e;

   // An address is in range when every word-index bit above the register
   // select field is zero.
   function automatic logic idx_in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [IDX_W-1:0] idx;
      idx = addr[ADDR_WIDTH-1:OFF_W];
      return (idx >> RIDX_W) == '0;
   endfunction

   function automatic logic [RIDX_W-1:0] reg_sel(input logic [ADDR_WIDTH-1:0] addr);
      return addr[OFF_W +: RIDX_W];
   endfunction

   // Byte offset bits, the W user field and ar_prot carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{lite_aw_addr[OFF_W-1:0], lite_ar_addr[OFF_W-1:0],
                            lite_w_user, lite_ar_prot, lite_aw_prot};

   // ------------------------------------------------------------------------
   // Write channel FSM
   // ------------------------------------------------------------------------
   wstate_e w_state_q, w_state_d;

   logic aw_fire, w_fire, b_fire;
   assign aw_fire = lite_aw_valid & lite_aw_ready;
   assign w_fire  = lite_w_valid  & lite_w_ready;
   assign b_fire  = lite_b_valid  & lite_b_ready;

   always_ff @(posedge clk) begin
      if (rst) w_state_q <= W_IDLE;
      else     w_state_q <= w_state_d;
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_fire) w_state_d = W_DATA;
         W_DATA:  if (w_fire)  w_state_d = W_RESP;
         W_RESP:  if (b_fire)  w_state_d = W_IDLE;
         default:              w_state_d = W_IDLE;
      endcase
   end

   // W is held off in W_IDLE, so a W beat arriving before AW simply waits.
   always_comb begin
      lite_aw_ready = 1'b0;
      lite_w_ready  = 1'b0;
      lite_b_valid  = 1'b0;
      case (w_state_q)
         W_IDLE:  lite_aw_ready = 1'b1;
         W_DATA:  lite_w_ready  = 1'b1;
         W_RESP:  lite_b_valid  = 1'b1;
         default: ;
      endcase
   end

   // Write address context and response payload
   logic [RIDX_W-1:0]     aw_idx_q;
   logic                  aw_inr_q;
   logic [ID_WIDTH-1:0]   b_id_q;
   logic [USER_WIDTH-1:0] b_user_q;
   logic [1:0]            b_resp_q;

   logic       wr_prot_ok;
   logic       wr_commit;
   logic [1:0] wr_resp;

`ifdef NASTI_LITE_REG_PROT_EN
   logic aw_priv_q;

   always_ff @(posedge clk) begin
      if (rst)          aw_priv_q <= 1'b0;
      else if (aw_fire) aw_priv_q <= lite_aw_prot[0];
   end

   assign wr_prot_ok = aw_priv_q;
`else
   assign wr_prot_ok = 1'b1;
`endif

   // Out-of-range takes precedence over the privilege check.
   always_comb begin
      if (!aw_inr_q)        wr_resp = RESP_DECERR;
      else if (!wr_prot_ok) wr_resp = RESP_SLVERR;
      else                  wr_resp = RESP_OKAY;
   end

   assign wr_commit = w_fire & aw_inr_q & wr_prot_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_idx_q <= '0;
         aw_inr_q <= 1'b0;
         b_id_q   <= '0;
         b_user_q <= '0;
         b_resp_q <= RESP_OKAY;
      end else begin
         if (aw_fire) begin
            aw_idx_q <= reg_sel(lite_aw_addr);
            aw_inr_q <= idx_in_range(lite_aw_addr);
            b_id_q   <= lite_aw_id;
            b_user_q <= lite_aw_user;
         end
         if (w_fire) b_resp_q <= wr_resp;
      end
   end

   assign lite_b_id   = b_id_q;
   assign lite_b_user = b_user_q;
   assign lite_b_resp = b_resp_q;

   // ------------------------------------------------------------------------
   // Register bank
   // ------------------------------------------------------------------------
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]                 reg_wr_q, reg_wr_d;

   // An all-zero strobe still counts as a write: no bytes change but the
   // pulse fires.
   always_comb begin
      regs_d   = regs_q;
      reg_wr_d = '0;
      if (wr_commit) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (lite_w_strb[k]) regs_d[aw_idx_q][k*8 +: 8] = lite_w_data[k*8 +: 8];
         end
         reg_wr_d[aw_idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q   <= '0;
         reg_wr_q <= '0;
      end else begin
         regs_q   <= regs_d;
         reg_wr_q <= reg_wr_d;
      end
   end

   assign reg_q  = regs_q;
   assign reg_wr = reg_wr_q;

   // ------------------------------------------------------------------------
   // Read channel FSM
   // ------------------------------------------------------------------------
   rstate_e r_state_q, r_state_d;

   logic ar_fire, r_fire;
   assign ar_fire = lite_ar_valid & lite_ar_ready;
   assign r_fire  = lite_r_valid  & lite_r_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state_q <= R_IDLE;
      else     r_state_q <= r_state_d;
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_fire) r_state_d = R_RESP;
         R_RESP:  if (r_fire)  r_state_d = R_IDLE;
         default:              r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      lite_ar_ready = 1'b0;
      lite_r_valid  = 1'b0;
      case (r_state_q)
         R_IDLE:  lite_ar_ready = 1'b1;
         R_RESP:  lite_r_valid  = 1'b1;
         default: ;
      endcase
   end

   // Read data is taken from regs_q, so a write landing on the same edge is
   // not yet visible to this read.
   logic [ID_WIDTH-1:0]   r_id_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q;
   logic [USER_WIDTH-1:0] r_user_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_q   <= '0;
         r_data_q <= '0;
         r_resp_q <= RESP_OKAY;
         r_user_q <= '0;
      end else if (ar_fire) begin
         r_id_q   <= lite_ar_id;
         r_user_q <= lite_ar_user;
         if (idx_in_range(lite_ar_addr)) begin
            r_data_q <= regs_q[reg_sel(lite_ar_addr)];
            r_resp_q <= RESP_OKAY;
         end else begin
            r_data_q <= '0;
            r_resp_q <= RESP_DECERR;
         end
      end
   end

   assign lite_r_id   = r_id_q;
   assign lite_r_data = r_data_q;
   assign lite_r_resp = r_resp_q;
   assign lite_r_user = r_user_q;

endmodule

// File: tb/tb_nasti_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_nasti_lite_reg_slave
//
// Bench for nasti_lite_reg_slave (NUM_REGS=8, DATA_WIDTH=32, ID_WIDTH=2).
// A transaction-level model (register array plus per-channel phase) predicts
// every handshake signal, response payload, reg_q and reg_wr each cycle;
// directed transactions pin the model with literal values, then concurrent
// random writes and reads run against it.
// ---------------------------------------------------------------------------
module tb_nasti_lite_reg_slave;

   localparam int IDW = 2;
   localparam int NR  = 8;
`ifdef NASTI_LITE_REG_PROT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [IDW-1:0] aw_id = '0;  logic [7:0] aw_addr = '0; logic [2:0] aw_prot = '0;
   logic aw_user = 1'b0, aw_valid = 1'b0, aw_ready;
   logic [31:0] w_data = '0; logic [3:0] w_strb = '0;
   logic w_user = 1'b0, w_valid = 1'b0, w_ready;
   logic [IDW-1:0] b_id; logic [1:0] b_resp; logic b_user, b_valid, b_ready = 1'b0;
   logic [IDW-1:0] ar_id = '0;  logic [7:0] ar_addr = '0; logic [2:0] ar_prot = '0;
   logic ar_user = 1'b0, ar_valid = 1'b0, ar_ready;
   logic [IDW-1:0] r_id; logic [31:0] r_data; logic [1:0] r_resp;
   logic r_user, r_valid, r_ready = 1'b0;
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0]    reg_wr;

   nasti_lite_reg_slave #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(8), .DATA_WIDTH(32), .USER_WIDTH(1), .NUM_REGS(NR)
   ) dut (
      .clk(clk), .rst(rst),
      .lite_aw_id(aw_id), .lite_aw_addr(aw_addr), .lite_aw_prot(aw_prot),
      .lite_aw_user(aw_user), .lite_aw_valid(aw_valid), .lite_aw_ready(aw_ready),
      .lite_w_data(w_data), .lite_w_strb(w_strb), .lite_w_user(w_user),
      .lite_w_valid(w_valid), .lite_w_ready(w_ready),
      .lite_b_id(b_id), .lite_b_resp(b_resp), .lite_b_user(b_user),
      .lite_b_valid(b_valid), .lite_b_ready(b_ready),
      .lite_ar_id(ar_id), .lite_ar_addr(ar_addr), .lite_ar_prot(ar_prot),
      .lite_ar_user(ar_user), .lite_ar_valid(ar_valid), .lite_ar_ready(ar_ready),
      .lite_r_id(r_id), .lite_r_data(r_data), .lite_r_resp(r_resp),
      .lite_r_user(r_user), .lite_r_valid(r_valid), .lite_r_ready(r_ready),
      .reg_q(reg_q), .reg_wr(reg_wr)
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   int wr3_cnt = 0;
   int wr_any_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // Write phase: 0 = waiting for AW, 1 = waiting for W, 2 = response owed.
   int          m_wph = 0, m_rph = 0;
   logic [31:0] m_regs [NR];
   logic [NR-1:0] m_wr = '0;
   int          m_widx = 0;
   logic [IDW-1:0] m_bid = '0; logic m_buser = 1'b0; logic m_wpriv = 1'b0;
   logic [1:0]  m_bresp = 2'b00;
   logic [IDW-1:0] m_rid = '0; logic m_ruser = 1'b0;
   logic [1:0]  m_rresp = 2'b00; logic [31:0] m_rdata = '0;

   initial for (int i = 0; i < NR; i++) m_regs[i] = '0;

   always @(negedge clk) begin
      logic [NR-1:0] wr_next;
      int ai;
      if (chk_en) begin
         chk("aw_ready", aw_ready, m_wph == 0);
         chk("w_ready",  w_ready,  m_wph == 1);
         chk("b_valid",  b_valid,  m_wph == 2);
         chk("ar_ready", ar_ready, m_rph == 0);
         chk("r_valid",  r_valid,  m_rph == 1);
         if (m_wph == 2) begin
            chk("b_id", b_id, m_bid);
            chk("b_resp", b_resp, m_bresp);
            chk("b_user", b_user, m_buser);
         end
         if (m_rph == 1) begin
            chk("r_id", r_id, m_rid);
            chk("r_data", r_data, m_rdata);
            chk("r_resp", r_resp, m_rresp);
            chk("r_user", r_user, m_ruser);
         end
         for (int i = 0; i < NR; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_regs[i]);
         chk("reg_wr", reg_wr, m_wr);
         wr3_cnt    += int'(reg_wr[3]);
         wr_any_cnt += $countones(reg_wr);
      end
      // advance the model across the coming rising edge
      wr_next = '0;
      if (rst) begin
         m_wph = 0; m_rph = 0;
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
      end else begin
         // reads sample the register array before this cycle's write lands
         if (m_rph == 0 && ar_valid) begin
            ai = int'(ar_addr) / 4;
            m_rdata = (ai < NR) ? m_regs[ai] : 32'h0;
            m_rresp = (ai < NR) ? 2'b00 : 2'b11;
            m_rid = ar_id; m_ruser = ar_user; m_rph = 1;
         end else if (m_rph == 1 && r_ready) begin
            m_rph = 0;
         end
         case (m_wph)
            0: if (aw_valid) begin
                  m_widx = int'(aw_addr) / 4; m_bid = aw_id; m_buser = aw_user;
                  m_wpriv = aw_prot[0]; m_wph = 1;
               end
            1: if (w_valid) begin
                  if (m_widx >= NR) m_bresp = 2'b11;
                  else if (PROT_EN && !m_wpriv) m_bresp = 2'b10;
                  else begin
                     for (int k = 0; k < 4; k++)
                        if (w_strb[k]) m_regs[m_widx][k*8 +: 8] = w_data[k*8 +: 8];
                     wr_next[m_widx] = 1'b1;
                     m_bresp = 2'b00;
                  end
                  m_wph = 2;
               end
            2: if (b_ready) m_wph = 0;
            default: m_wph = 0;
         endcase
      end
      m_wr = wr_next;
   end

   // ---------------- drivers ----------------
   // Wait (bounded) until the selected DUT signal is high in a cycle, then
   // step to just after that rising edge.
   task automatic wait_hi(input int sel, input string nm);
      int n = 0;
      bit done = 1'b0;
      logic s;
      while (!done) begin
         @(negedge clk);
         case (sel)
            0: s = aw_ready; 1: s = w_ready; 2: s = b_valid;
            3: s = ar_ready; default: s = r_valid;
         endcase
         if (s) done = 1'b1;
         else if (++n > 60) begin
            checks++; failures++;
            $display("FAIL timeout_%s actual=0 required=1", nm);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic wr_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [IDW-1:0] id, input logic u, input logic [2:0] p,
                         input int w_lead, input int b_hold,
                         output logic [1:0] resp, output logic [IDW-1:0] rid);
      w_data = d; w_strb = s; w_user = ~u;
      if (w_lead > 0) begin
         w_valid = 1'b1;
         repeat (w_lead) @(posedge clk);
         #1;
      end
      aw_addr = a; aw_id = id; aw_user = u; aw_prot = p; aw_valid = 1'b1;
      wait_hi(0, "aw");
      aw_valid = 1'b0; w_valid = 1'b1;
      wait_hi(1, "w");
      w_valid = 1'b0;
      repeat (b_hold) @(posedge clk);
      #1 b_ready = 1'b1;
      @(negedge clk);
      resp = b_resp; rid = b_id;
      @(posedge clk); #1;
      if (!b_valid) ;
      b_ready = 1'b0;
      // first sampled negedge might precede b_valid only when b_hold is 0;
      // W was accepted on the previous edge so b_valid is already up.
   endtask

   task automatic rd_txn(input logic [7:0] a, input logic [IDW-1:0] id, input logic u,
                         input int r_hold, output logic [31:0] d, output logic [1:0] resp);
      ar_addr = a; ar_id = id; ar_user = u; ar_prot = 3'($urandom_range(0, 7)); ar_valid = 1'b1;
      wait_hi(3, "ar");
      ar_valid = 1'b0;
      repeat (r_hold) @(posedge clk);
      #1 r_ready = 1'b1;
      @(negedge clk);
      d = r_data; resp = r_resp;
      @(posedge clk); #1;
      r_ready = 1'b0;
   endtask

   task automatic rand_writes(input int n);
      logic [1:0] rs; logic [IDW-1:0] ri; logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
         wr_txn(a, $urandom, 4'($urandom), IDW'($urandom), 1'($urandom), 3'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), rs, ri);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_reads(input int n);
      logic [31:0] d; logic [1:0] rs; logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
         rd_txn(a, IDW'($urandom), 1'($urandom), $urandom_range(0, 3), d, rs);
         repeat ($urandom_range(0, 1)) @(posedge clk);
         #1;
      end
   endtask

   // ---------------- directed sequence + random phase ----------------
   initial begin
      logic [1:0] rs; logic [IDW-1:0] ri; logic [31:0] rd;
      int c0, a0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_aw_ready", aw_ready, 1'b1);
      chk("rst_ar_ready", ar_ready, 1'b1);
      chk("rst_w_ready", w_ready, 1'b0);
      chk("rst_b_valid", b_valid, 1'b0);
      chk("rst_r_valid", r_valid, 1'b0);
      chk("rst_b_fields", {b_id, b_resp, b_user}, '0);
      chk("rst_r_fields", {r_id, r_data, r_resp, r_user}, '0);
      chk("rst_reg_q_lo", reg_q[127:0], '0);
      chk("rst_reg_q_hi", reg_q[255:128], '0);
      chk("rst_reg_wr", reg_wr, '0);
      chk_en = 1'b1;
      @(posedge clk); #1;

      // full write then readback
      c0 = wr3_cnt;
      wr_txn(8'h0C, 32'hDEADBEEF, 4'hF, 2'd1, 1'b1, 3'b001, 0, 0, rs, ri);
      chk("wr3_resp", rs, 2'b00);
      chk("wr3_bid", ri, 2'd1);
      @(posedge clk); #1;
      chk("wr3_pulses", wr3_cnt - c0, 1);
      chk("reg3_val", reg_q[3*32 +: 32], 32'hDEADBEEF);
      rd_txn(8'h0C, 2'd2, 1'b0, 0, rd, rs);
      chk("rd3_data", rd, 32'hDEADBEEF);
      chk("rd3_resp", rs, 2'b00);

      // partial write
      wr_txn(8'h08, 32'h11223344, 4'hF, 2'd0, 1'b0, 3'b001, 0, 1, rs, ri);
      wr_txn(8'h0A, 32'hAABBCCDD, 4'h5, 2'd3, 1'b1, 3'b001, 0, 0, rs, ri);
      chk("reg2_partial", reg_q[2*32 +: 32], 32'h11BB33DD);

      // out of range
      a0 = wr_any_cnt;
      wr_txn(8'h40, 32'h12345678, 4'hF, 2'd2, 1'b0, 3'b001, 0, 0, rs, ri);
      chk("oor_wr_resp", rs, 2'b11);
      rd_txn(8'h40, 2'd1, 1'b1, 1, rd, rs);
      chk("oor_rd_resp", rs, 2'b11);
      chk("oor_rd_data", rd, 32'h0);
      chk("oor_no_pulse", wr_any_cnt - a0, 0);

      // W before AW with B backpressure
      wr_txn(8'h10, 32'hCAFEF00D, 4'hF, 2'd3, 1'b1, 3'b001, 3, 5, rs, ri);
      chk("bp_resp", rs, 2'b00);
      chk("bp_bid", ri, 2'd3);
      chk("reg4_val", reg_q[4*32 +: 32], 32'hCAFEF00D);

      // zero strobe
      c0 = wr3_cnt;
      wr_txn(8'h0C, 32'h0, 4'h0, 2'd0, 1'b0, 3'b001, 0, 0, rs, ri);
      @(posedge clk); #1;
      chk("zstrb_resp", rs, 2'b00);
      chk("zstrb_reg3", reg_q[3*32 +: 32], 32'hDEADBEEF);
      chk("zstrb_pulse", wr3_cnt - c0, 1);

`ifdef NASTI_LITE_REG_PROT_EN
      wr_txn(8'h04, 32'h55AA55AA, 4'hF, 2'd1, 1'b0, 3'b000, 0, 0, rs, ri);
      chk("prot0_resp", rs, 2'b10);
      chk("prot0_reg1", reg_q[1*32 +: 32], 32'h0);
      wr_txn(8'h04, 32'h55AA55AA, 4'hF, 2'd1, 1'b0, 3'b001, 0, 0, rs, ri);
      chk("prot1_resp", rs, 2'b00);
      chk("prot1_reg1", reg_q[1*32 +: 32], 32'h55AA55AA);
`endif

      // concurrent random traffic
      fork
         rand_writes(80);
         rand_reads(120);
      join

      // reset while a write is waiting for its data beat
      aw_addr = 8'h14; aw_id = 2'd1; aw_user = 1'b0; aw_prot = 3'b001; aw_valid = 1'b1;
      wait_hi(0, "aw_mid");
      aw_valid = 1'b0;
      w_data = 32'hFFFFFFFF; w_strb = 4'hF; w_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      chk("midrst_reg5", reg_q[5*32 +: 32], 32'h0);
      chk("midrst_b_valid", b_valid, 1'b0);
      chk("midrst_aw_ready", aw_ready, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
